// File: rtl/cnn_layer_accel_awe_pkg.sv
// Shared types and widths for the AWE row-buffer read sequencer.
// Widths mirror the accelerator defines header (pixel width, CEs per AWE,
// kernel size, dimension width). The beat struct is sized from these
// constants, so the sequencer parameters must keep their default values.
package cnn_layer_accel_awe_pkg;

    localparam int PIXEL_WIDTH    = 16;
    localparam int NUM_CE_PER_AWE = 2;
    localparam int KERNEL_SIZE    = 3;
    localparam int DIM_WIDTH      = 10;
    localparam int WORD_WIDTH     = PIXEL_WIDTH * NUM_CE_PER_AWE;
    localparam int CYC_WIDTH      = 3;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    // One CE beat: pixel word plus the tags that travel with it.
    typedef struct packed {
        logic [WORD_WIDTH-1:0] data;
        logic [DIM_WIDTH-1:0]  row;
        logic [DIM_WIDTH-1:0]  col;
        logic                  last_kernel;
        logic [CYC_WIDTH-1:0]  cycle;
    } beat_t;

endpackage

// File: rtl/cnn_layer_accel_awe_rb_loop_ctr.sv
// Four-level loop nest for the row-buffer read sequencer.
// Inner to outer: tap cycle (0..K-1), kernel, column pair (step 2), row.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr_i           restart the nest at zero (frame start)
//   step_i          advance the nest by one tap
//   num_*_i         latched frame dimensions (all non-zero while stepping)
//   cyc_o, col_o, row_o   current position (col_o is the even column)
//   kern_last_o     current kernel is the last one
//   frame_last_o    current position is the final tap of the frame
module cnn_layer_accel_awe_rb_loop_ctr
    import cnn_layer_accel_awe_pkg::*;
#(
    parameter int C_KERNEL_SIZE = KERNEL_SIZE,
    parameter int C_DIM_WIDTH   = DIM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   step_i,
    input  logic [C_DIM_WIDTH-1:0] num_rows_i,
    input  logic [C_DIM_WIDTH-1:0] num_cols_i,
    input  logic [C_DIM_WIDTH-1:0] num_kernels_i,
    output logic [CYC_WIDTH-1:0]   cyc_o,
    output logic                   kern_last_o,
    output logic [C_DIM_WIDTH-1:0] col_o,
    output logic [C_DIM_WIDTH-1:0] row_o,
    output logic                   frame_last_o
);
    localparam logic [CYC_WIDTH-1:0]   CYC_MAX  = CYC_WIDTH'(C_KERNEL_SIZE - 1);
    localparam logic [C_DIM_WIDTH:0]   COL_STEP = (C_DIM_WIDTH + 1)'(2);
    localparam logic [C_DIM_WIDTH-1:0] ONE      = C_DIM_WIDTH'(1);

    logic [CYC_WIDTH-1:0]   cyc_q, cyc_d;
    logic [C_DIM_WIDTH-1:0] kern_q, kern_d;
    logic [C_DIM_WIDTH-1:0] col_q, col_d;
    logic [C_DIM_WIDTH-1:0] row_q, row_d;
    logic cyc_last, kern_last, col_last, row_last;

    assign cyc_last  = (cyc_q == CYC_MAX);
    assign kern_last = (kern_q == num_kernels_i - ONE);
    // Extra bit so an odd column count near 2^D does not wrap the compare.
    assign col_last  = (({1'b0, col_q} + COL_STEP) >= {1'b0, num_cols_i});
    assign row_last  = (row_q == num_rows_i - ONE);

    always_comb begin
        cyc_d  = cyc_q;
        kern_d = kern_q;
        col_d  = col_q;
        row_d  = row_q;
        if (clr_i) begin
            cyc_d  = '0;
            kern_d = '0;
            col_d  = '0;
            row_d  = '0;
        end else if (step_i) begin
            if (!cyc_last) begin
                cyc_d = cyc_q + CYC_WIDTH'(1);
            end else begin
                cyc_d = '0;
                if (!kern_last) begin
                    kern_d = kern_q + ONE;
                end else begin
                    kern_d = '0;
                    if (!col_last) begin
                        col_d = col_q + C_DIM_WIDTH'(2);
                    end else begin
                        col_d = '0;
                        row_d = row_last ? '0 : row_q + ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            kern_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            cyc_q  <= cyc_d;
            kern_q <= kern_d;
            col_q  <= col_d;
            row_q  <= row_d;
        end
    end

    assign cyc_o        = cyc_q;
    assign kern_last_o  = kern_last;
    assign col_o        = col_q;
    assign row_o        = row_q;
    assign frame_last_o = cyc_last & kern_last & col_last & row_last;

endmodule

// File: rtl/cnn_layer_accel_awe_rowbuf_rd_seq.sv
// Row-buffer read sequencer for one AWE. Walks the loop nest, reads a column
// slice from each row buffer per tap and presents the pair as lockstep beats
// on the two CE streams (ce0 = even column, ce1 = odd column).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, cfg_*               frame request; cfg latched on accepted start
//   busy, done                 frame in progress / 1-cycle completion pulse
//   rbN_rd_en/addr/data        row-buffer read ports (1-cycle latency, data
//                              held while rd_en low)
//   ce_rdy                     CE pair accepts the current beat
//   ceN_*/output_*_ceN         beat data, valid, row/col tags, last kernel,
//                              tap index
// Pipeline: read issued (stage 1 holds tags) -> output register loads the
// read data with its tags. Both stages move only on advance, so a stall
// freezes everything and relies on the BRAM holding its data.
module cnn_layer_accel_awe_rowbuf_rd_seq
    import cnn_layer_accel_awe_pkg::*;
#(
    parameter int C_PIXEL_WIDTH    = PIXEL_WIDTH,
    parameter int C_NUM_CE_PER_AWE = NUM_CE_PER_AWE,
    parameter int C_KERNEL_SIZE    = KERNEL_SIZE,
    parameter int C_DIM_WIDTH      = DIM_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [C_DIM_WIDTH-1:0]                    cfg_num_out_rows,
    input  logic [C_DIM_WIDTH-1:0]                    cfg_num_out_cols,
    input  logic [C_DIM_WIDTH-1:0]                    cfg_num_kernels,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      rb0_rd_en,
    output logic                                      rb1_rd_en,
    output logic [C_DIM_WIDTH-1:0]                    rb0_rd_addr,
    output logic [C_DIM_WIDTH-1:0]                    rb1_rd_addr,
    input  logic [C_PIXEL_WIDTH*C_NUM_CE_PER_AWE-1:0] rb0_rd_data,
    input  logic [C_PIXEL_WIDTH*C_NUM_CE_PER_AWE-1:0] rb1_rd_data,
    input  logic                                      ce_rdy,
    output logic [C_PIXEL_WIDTH*C_NUM_CE_PER_AWE-1:0] ce0_pixel_dataout,
    output logic [C_PIXEL_WIDTH*C_NUM_CE_PER_AWE-1:0] ce1_pixel_dataout,
    output logic                                      ce0_pixel_dataout_valid,
    output logic                                      ce1_pixel_dataout_valid,
    output logic [C_DIM_WIDTH-1:0]                    output_row_ce0,
    output logic [C_DIM_WIDTH-1:0]                    output_row_ce1,
    output logic [C_DIM_WIDTH-1:0]                    output_col_ce0,
    output logic [C_DIM_WIDTH-1:0]                    output_col_ce1,
    output logic                                      ce0_last_kernel,
    output logic                                      ce1_last_kernel,
    output logic [CYC_WIDTH-1:0]                      ce0_cycle_counter,
    output logic [CYC_WIDTH-1:0]                      ce1_cycle_counter
);
    localparam int D = C_DIM_WIDTH;

    state_e state_q, state_d;
    logic [D-1:0] rows_q, rows_d, cols_q, cols_d, kerns_q, kerns_d;
    logic         s1_vld0_q, s1_vld0_d, s1_vld1_q, s1_vld1_d;
    logic [D-1:0] s1_row_q, s1_row_d, s1_col_q, s1_col_d;
    logic         s1_lk_q, s1_lk_d;
    logic [CYC_WIDTH-1:0] s1_cyc_q, s1_cyc_d;
    logic         vld0_q, vld0_d, vld1_q, vld1_d;
    beat_t        out0_q, out0_d, out1_q, out1_d;

    logic [CYC_WIDTH-1:0] cyc;
    logic [D-1:0] col, row;
    logic kern_last, frame_last;
    logic accept, cfg_zero, advance, active, issue, ce1_in_rng;

    assign accept   = (state_q == IDLE) && start;
    assign cfg_zero = (cfg_num_out_rows == '0) || (cfg_num_out_cols == '0) ||
                      (cfg_num_kernels == '0);
    assign advance  = !vld0_q || ce_rdy;
    assign active   = (state_q == PRIME) || (state_q == STREAM);
    assign issue    = active && advance;
    // Odd column count: the final pair of each row has no odd partner.
    assign ce1_in_rng = (({1'b0, col} + (D + 1)'(1)) < {1'b0, cols_q});

    cnn_layer_accel_awe_rb_loop_ctr #(
        .C_KERNEL_SIZE (C_KERNEL_SIZE),
        .C_DIM_WIDTH   (D)
    ) u_loop (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_i         (accept),
        .step_i        (issue),
        .num_rows_i    (rows_q),
        .num_cols_i    (cols_q),
        .num_kernels_i (kerns_q),
        .cyc_o         (cyc),
        .kern_last_o   (kern_last),
        .col_o         (col),
        .row_o         (row),
        .frame_last_o  (frame_last)
    );

    assign rb0_rd_en   = issue;
    assign rb1_rd_en   = issue && ce1_in_rng;
    // Addresses wrap modulo 2^D; zero outside the read window keeps reset quiet.
    assign rb0_rd_addr = active ? col + D'(cyc) : '0;
    assign rb1_rd_addr = active ? col + D'(cyc) + D'(1) : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = cfg_zero ? DONE : PRIME;
            PRIME:   state_d = frame_last ? DRAIN : STREAM;
            STREAM:  if (advance && frame_last) state_d = DRAIN;
            // Stage 1 empty and output accepted (or already empty).
            DRAIN:   if (!s1_vld0_q && advance) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rows_d    = accept ? cfg_num_out_rows : rows_q;
        cols_d    = accept ? cfg_num_out_cols : cols_q;
        kerns_d   = accept ? cfg_num_kernels  : kerns_q;
        s1_vld0_d = s1_vld0_q;
        s1_vld1_d = s1_vld1_q;
        s1_row_d  = s1_row_q;
        s1_col_d  = s1_col_q;
        s1_lk_d   = s1_lk_q;
        s1_cyc_d  = s1_cyc_q;
        vld0_d    = vld0_q;
        vld1_d    = vld1_q;
        out0_d    = out0_q;
        out1_d    = out1_q;
        if (advance) begin
            s1_vld0_d = issue;
            s1_vld1_d = rb1_rd_en;
            if (issue) begin
                s1_row_d = row;
                s1_col_d = col;
                s1_lk_d  = kern_last;
                s1_cyc_d = cyc;
            end
            // Tags only reload with a real beat; a bubble just drops valid.
            vld0_d = s1_vld0_q;
            vld1_d = s1_vld1_q;
            if (s1_vld0_q) begin
                out0_d.data        = rb0_rd_data;
                out0_d.row         = s1_row_q;
                out0_d.col         = s1_col_q;
                out0_d.last_kernel = s1_lk_q;
                out0_d.cycle       = s1_cyc_q;
            end
            if (s1_vld1_q) begin
                out1_d.data        = rb1_rd_data;
                out1_d.row         = s1_row_q;
                out1_d.col         = s1_col_q + D'(1);
                out1_d.last_kernel = s1_lk_q;
                out1_d.cycle       = s1_cyc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            kerns_q   <= '0;
            s1_vld0_q <= 1'b0;
            s1_vld1_q <= 1'b0;
            s1_row_q  <= '0;
            s1_col_q  <= '0;
            s1_lk_q   <= 1'b0;
            s1_cyc_q  <= '0;
            vld0_q    <= 1'b0;
            vld1_q    <= 1'b0;
            out0_q    <= '0;
            out1_q    <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            kerns_q   <= kerns_d;
            s1_vld0_q <= s1_vld0_d;
            s1_vld1_q <= s1_vld1_d;
            s1_row_q  <= s1_row_d;
            s1_col_q  <= s1_col_d;
            s1_lk_q   <= s1_lk_d;
            s1_cyc_q  <= s1_cyc_d;
            vld0_q    <= vld0_d;
            vld1_q    <= vld1_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    assign ce0_pixel_dataout       = out0_q.data;
    assign ce0_pixel_dataout_valid = vld0_q;
    assign output_row_ce0          = out0_q.row;
    assign output_col_ce0          = out0_q.col;
    assign ce0_last_kernel         = out0_q.last_kernel;
    assign ce0_cycle_counter       = out0_q.cycle;
    assign ce1_pixel_dataout       = out1_q.data;
    assign ce1_pixel_dataout_valid = vld1_q;
    assign output_row_ce1          = out1_q.row;
    assign output_col_ce1          = out1_q.col;
    assign ce1_last_kernel         = out1_q.last_kernel;
    assign ce1_cycle_counter       = out1_q.cycle;

endmodule

// File: tb/tb_cnn_layer_accel_awe_rowbuf_rd_seq.sv
module tb_cnn_layer_accel_awe_rowbuf_rd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  cfg_rows = '0, cfg_cols = '0, cfg_kerns = '0;
    logic        busy, done;
    logic        rb0_rd_en, rb1_rd_en;
    logic [9:0]  rb0_rd_addr, rb1_rd_addr;
    logic [31:0] rb0_rd_data = '0, rb1_rd_data = '0;
    logic        ce_rdy = 1'b0;
    logic [31:0] ce0_data, ce1_data;
    logic        ce0_v, ce1_v;
    logic [9:0]  row0, row1, col0, col1;
    logic        lk0, lk1;
    logic [2:0]  cyc0, cyc1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnn_layer_accel_awe_rowbuf_rd_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_num_out_rows(cfg_rows), .cfg_num_out_cols(cfg_cols), .cfg_num_kernels(cfg_kerns),
        .busy(busy), .done(done),
        .rb0_rd_en(rb0_rd_en), .rb1_rd_en(rb1_rd_en),
        .rb0_rd_addr(rb0_rd_addr), .rb1_rd_addr(rb1_rd_addr),
        .rb0_rd_data(rb0_rd_data), .rb1_rd_data(rb1_rd_data),
        .ce_rdy(ce_rdy),
        .ce0_pixel_dataout(ce0_data), .ce1_pixel_dataout(ce1_data),
        .ce0_pixel_dataout_valid(ce0_v), .ce1_pixel_dataout_valid(ce1_v),
        .output_row_ce0(row0), .output_row_ce1(row1),
        .output_col_ce0(col0), .output_col_ce1(col1),
        .ce0_last_kernel(lk0), .ce1_last_kernel(lk1),
        .ce0_cycle_counter(cyc0), .ce1_cycle_counter(cyc1)
    );

    // Row-buffer contents are a tagged function of the address.
    function automatic logic [31:0] f0(input int a);
        return 32'h00A0_0000 | (32'(a) & 32'h3FF);
    endfunction
    function automatic logic [31:0] f1(input int a);
        return 32'h00B1_0000 | (32'(a) & 32'h3FF);
    endfunction

    always @(posedge clk) begin
        if (rb0_rd_en) rb0_rd_data <= f0(int'(rb0_rd_addr));
        if (rb1_rd_en) rb1_rd_data <= f1(int'(rb1_rd_addr));
    end

    function automatic logic [55:0] pk(input logic [31:0] d, input int r, input int c,
                                       input bit lk, input int y);
        return {d, 10'(r), 10'(c), lk, 3'(y)};
    endfunction
    function automatic logic [55:0] obs0();
        return {ce0_data, row0, col0, lk0, cyc0};
    endfunction
    function automatic logic [55:0] obs1();
        return {ce1_data, row1, col1, lk1, cyc1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {busy, done, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v}, 6'b0);
        chk({tag, "_addr"}, {rb0_rd_addr, rb1_rd_addr}, 20'd0);
        chk({tag, "_ce0"}, obs0(), 56'd0);
        chk({tag, "_ce1"}, obs1(), 56'd0);
    endtask

    // rows=1 cols=2 kern=1: three beats, addresses 0/1,1/2,2/3.
    // ctl = {busy, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v, done}
    task automatic directed_t1(input string tag);
        cfg_rows = 10'd1; cfg_cols = 10'd2; cfg_kerns = 10'd1; ce_rdy = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "_c0_ctl"}, {busy, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v, done}, 6'b111000);
        chk({tag, "_c0_addr"}, {rb0_rd_addr, rb1_rd_addr}, {10'd0, 10'd1});
        @(negedge clk);
        chk({tag, "_c1_ctl"}, {busy, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v, done}, 6'b111000);
        chk({tag, "_c1_addr"}, {rb0_rd_addr, rb1_rd_addr}, {10'd1, 10'd2});
        @(negedge clk);
        chk({tag, "_c2_ctl"}, {busy, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v, done}, 6'b111110);
        chk({tag, "_c2_addr"}, {rb0_rd_addr, rb1_rd_addr}, {10'd2, 10'd3});
        chk({tag, "_b0_ce0"}, obs0(), pk(f0(0), 0, 0, 1'b1, 0));
        chk({tag, "_b0_ce1"}, obs1(), pk(f1(1), 0, 1, 1'b1, 0));
        @(negedge clk);
        chk({tag, "_c3_ctl"}, {busy, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v, done}, 6'b100110);
        chk({tag, "_b1_ce0"}, obs0(), pk(f0(1), 0, 0, 1'b1, 1));
        chk({tag, "_b1_ce1"}, obs1(), pk(f1(2), 0, 1, 1'b1, 1));
        @(negedge clk);
        chk({tag, "_c4_ctl"}, {busy, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v, done}, 6'b100110);
        chk({tag, "_b2_ce0"}, obs0(), pk(f0(2), 0, 0, 1'b1, 2));
        chk({tag, "_b2_ce1"}, obs1(), pk(f1(3), 0, 1, 1'b1, 2));
        @(negedge clk);
        chk({tag, "_c5_ctl"}, {busy, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v, done}, 6'b100001);
        @(negedge clk);
        chk({tag, "_c6_ctl"}, {busy, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v, done}, 6'b000000);
    endtask

    // Scoreboarded frame. rnd: random ce_rdy; poke: second start while busy;
    // stop_after > 0: return right after that many accepted beats.
    task automatic run_frame(input int rows, input int cols, input int kerns,
                             input bit rnd, input bit poke, input int stop_after);
        logic [55:0] q0[$];
        logic [55:0] q1[$];
        bit          qv1[$];
        logic [56:0] snap0, snap1;
        logic [19:0] last1;
        bit have_last1 = 0, stall = 0, exp_done = 0, fin = 0;
        int acc = 0;
        logic r;
        for (int rr = 0; rr < rows; rr++)
            for (int c = 0; c < cols; c += 2)
                for (int k = 0; k < kerns; k++)
                    for (int y = 0; y < 3; y++) begin
                        q0.push_back(pk(f0(c + y), rr, c, k == kerns - 1, y));
                        qv1.push_back(c + 1 < cols);
                        q1.push_back(pk(f1(c + 1 + y), rr, c + 1, k == kerns - 1, y));
                    end
        cfg_rows = 10'(rows); cfg_cols = 10'(cols); cfg_kerns = 10'(kerns);
        ce_rdy = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int it = 0; it < 3000 && !fin; it++) begin
            if (stall) begin
                chk("stall_hold_ce0", {ce0_v, obs0()}, snap0);
                chk("stall_hold_ce1", {ce1_v, obs1()}, snap1);
            end
            chk("done", done, exp_done);
            if (exp_done) begin
                fin = 1;
            end else begin
                start = poke && (it == 1);
                if (poke && it == 1) begin
                    cfg_rows = 10'd3; cfg_cols = 10'd5; cfg_kerns = 10'd2;
                end
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                ce_rdy = r;
                #1;
                chk("ce1_implies_ce0", ce1_v & ~ce0_v, 1'b0);
                if (ce0_v && !r) chk("stall_rden", {rb0_rd_en, rb1_rd_en}, 2'b00);
                stall = ce0_v && !r;
                snap0 = {ce0_v, obs0()};
                snap1 = {ce1_v, obs1()};
                if (ce0_v && r) begin
                    if (q0.size() == 0) begin
                        chk("extra_beat", ce0_v, 1'b0);
                    end else begin
                        chk("ce0_beat", obs0(), q0[0]);
                        chk("ce1_valid", ce1_v, qv1[0]);
                        if (qv1[0]) begin
                            chk("ce1_beat", obs1(), q1[0]);
                            last1 = q1[0][23:4];
                            have_last1 = 1;
                        end else if (have_last1) begin
                            chk("ce1_tag_hold", {row1, col1}, last1);
                        end
                        void'(q0.pop_front()); void'(q1.pop_front()); void'(qv1.pop_front());
                        acc++;
                        if (q0.size() == 0) exp_done = 1;
                        if (acc == stop_after) fin = 1;
                    end
                end
                if (!fin) @(negedge clk);
            end
        end
        start = 1'b0;
        chk("frame_finished", fin, 1'b1);
        if (exp_done && acc != stop_after) begin
            @(negedge clk);
            chk("post_done", {busy, done}, 2'b00);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);

        directed_t1("t1");

        run_frame(2, 3, 2, 1'b0, 1'b0, -1);
        run_frame(2, 4, 2, 1'b1, 1'b0, -1);

        // Zero column count: straight to DONE, no reads, no beats.
        cfg_rows = 10'd1; cfg_cols = 10'd0; cfg_kerns = 10'd1; ce_rdy = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t4_c0_ctl", {busy, done, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v}, 6'b110000);
        @(negedge clk);
        chk("t4_c1_ctl", {busy, done, rb0_rd_en, rb1_rd_en, ce0_v, ce1_v}, 6'b000000);

        // Async reset after the 7th beat, then a clean repeat of test 1.
        run_frame(2, 3, 2, 1'b0, 1'b0, 7);
        #1 rst_n = 1'b0;
        #1 chk_quiet("t5_async_rst");
        @(negedge clk);
        chk_quiet("t5_rst_held");
        rst_n = 1'b1;
        @(negedge clk);
        directed_t1("t5_t1");

        run_frame(1, 2, 1, 1'b0, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
